// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC send path: table entry layout, packet layout,
// fanout FSM states and the table sizing constants.
package dircc_types_pkg;

  localparam int MAX_DEVICES = 16;
  localparam int MAX_PORTS   = 4;
  localparam int MAX_TARGETS = 64;
  localparam int PAYLOAD_W   = 32;
  localparam int LAMPORT_W   = 32;

  localparam int DW = $clog2(MAX_DEVICES);
  localparam int PW = $clog2(MAX_PORTS);
  localparam int TW = $clog2(MAX_TARGETS);

  localparam logic [TW:0] MAX_COUNT = (TW+1)'(MAX_TARGETS);

  localparam logic [7:0] DIRCC_ADDRESS_FLAG_NONE     = 8'd0;
  localparam logic [7:0] DIRCC_ADDRESS_FLAG_DISABLED = 8'd1;

  typedef struct packed {
    logic [15:0] hw_node;
    logic [7:0]  sw_node;
    logic [7:0]  port;
    logic [7:0]  flag;
  } address_t;

  typedef struct packed {
    address_t               dst;
    logic [DW-1:0]          src_dev;
    logic [PW-1:0]          src_port;
    logic [LAMPORT_W-1:0]   lamport;
    logic [PAYLOAD_W-1:0]   payload;
  } dircc_fanout_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESC,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } fanout_state_e;

  // Descriptor counts above the table depth would otherwise revisit entries.
  function automatic logic [TW:0] clamp_count(input logic [TW:0] count);
    return (count > MAX_COUNT) ? MAX_COUNT : count;
  endfunction

endpackage

// File: rtl/dircc_lamport_clock.sv
// Per-thread Lamport clock: merges received timestamps and counts local sends.
// Shared between the send and receive stages.
module dircc_lamport_clock
  import dircc_types_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_valid_i,
  input  logic [LAMPORT_W-1:0] rx_i,
  input  logic                 send_i,
  output logic [LAMPORT_W-1:0] lamport_o,
  output logic [LAMPORT_W-1:0] lamport_next_o
);

  logic [LAMPORT_W-1:0] lamport_q, lamport_d, merged;
  logic [1:0]           inc;

  // A simultaneous receive and send each tick the clock once after the merge.
  always_comb begin
    merged    = (rx_valid_i && (rx_i > lamport_q)) ? rx_i : lamport_q;
    inc       = {1'b0, rx_valid_i} + {1'b0, send_i};
    lamport_d = merged + LAMPORT_W'(inc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lamport_q <= '0;
    else          lamport_q <= lamport_d;
  end

  assign lamport_o      = lamport_q;
  assign lamport_next_o = lamport_d;

endmodule

// File: rtl/dircc_fanout_sender.sv
// Send-side fanout: one request becomes one packet per enabled target of the
// source port, each stamped with the Lamport value taken at accept time.
module dircc_fanout_sender
  import dircc_types_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DW-1:0]         req_dev,
  input  logic [PW-1:0]         req_port,
  input  logic [PAYLOAD_W-1:0]  req_payload,
  output logic                  desc_rd_en,
  output logic [DW+PW-1:0]      desc_rd_idx,
  input  logic [TW-1:0]         desc_base,
  input  logic [TW:0]           desc_count,
  output logic                  addr_rd_en,
  output logic [TW-1:0]         addr_rd_idx,
  input  address_t              addr_rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output dircc_fanout_pkt_t     pkt_data,
  input  logic                  lamport_rx_valid,
  input  logic [LAMPORT_W-1:0]  lamport_rx,
  output logic [LAMPORT_W-1:0]  lamport,
  output logic                  req_done,
  output logic                  busy
);

  fanout_state_e          state_q, state_d;
  logic [TW-1:0]          base_q, base_d;
  logic [TW:0]            count_q, count_d;
  logic [TW:0]            i_q, i_d;
  address_t               dst_q, dst_d;
  logic [DW-1:0]          dev_q;
  logic [PW-1:0]          port_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [LAMPORT_W-1:0]   stamp_q;
  logic [LAMPORT_W-1:0]   lamport_next;
  logic                   accept;

  dircc_lamport_clock u_lamport (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_valid_i     (lamport_rx_valid),
    .rx_i           (lamport_rx),
    .send_i         (accept),
    .lamport_o      (lamport),
    .lamport_next_o (lamport_next)
  );

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    i_d        = i_q;
    dst_d      = dst_q;
    req_ready  = 1'b0;
    accept     = 1'b0;
    desc_rd_en = 1'b0;
    addr_rd_en = 1'b0;
    pkt_valid  = 1'b0;
    req_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          desc_rd_en = 1'b1;
          state_d    = ST_DESC;
        end
      end
      ST_DESC: begin
        base_d  = desc_base;
        count_d = clamp_count(desc_count);
        i_d     = '0;
        if (count_d == '0) begin
          state_d = ST_DONE;
        end else begin
          addr_rd_en = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        i_d = i_q + 1'b1;
        if (addr_rd_data.flag == DIRCC_ADDRESS_FLAG_DISABLED) begin
          if (i_d < count_q) addr_rd_en = 1'b1;
          else               state_d    = ST_DONE;
        end else begin
          dst_d   = addr_rd_data;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        pkt_valid = 1'b1;
        if (pkt_ready) begin
          if (i_q < count_q) begin
            addr_rd_en = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        req_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The first read in DESC uses the base straight off the descriptor port.
    addr_rd_idx = (state_q == ST_DESC) ? desc_base : base_q + i_d[TW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      i_q     <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      i_q     <= i_d;
      dst_q   <= dst_d;
    end
  end

  // NOTE: request datapath registers carry no reset; nothing reads them before an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      dev_q     <= req_dev;
      port_q    <= req_port;
      payload_q <= req_payload;
      stamp_q   <= lamport_next;
    end
  end

  assign desc_rd_idx = {req_dev, req_port};
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    pkt_data          = '0;
    pkt_data.dst      = dst_q;
    pkt_data.src_dev  = dev_q;
    pkt_data.src_port = port_q;
    pkt_data.lamport  = stamp_q;
    pkt_data.payload  = payload_q;
  end

endmodule

// File: tb/tb_dircc_fanout_sender.sv
// Directed bench for the fanout sender: memory models for both tables, a
// packet monitor and a small reference model of the fanout and Lamport clock.
module tb_dircc_fanout_sender;
  import dircc_types_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid, req_ready;
  logic [DW-1:0]         req_dev;
  logic [PW-1:0]         req_port;
  logic [PAYLOAD_W-1:0]  req_payload;
  logic                  desc_rd_en;
  logic [DW+PW-1:0]      desc_rd_idx;
  logic [TW-1:0]         desc_base;
  logic [TW:0]           desc_count;
  logic                  addr_rd_en;
  logic [TW-1:0]         addr_rd_idx;
  address_t              addr_rd_data;
  logic                  pkt_valid, pkt_ready;
  dircc_fanout_pkt_t     pkt_data;
  logic                  lamport_rx_valid;
  logic [LAMPORT_W-1:0]  lamport_rx, lamport;
  logic                  req_done, busy;

  dircc_fanout_sender dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dev(req_dev),
    .req_port(req_port), .req_payload(req_payload),
    .desc_rd_en(desc_rd_en), .desc_rd_idx(desc_rd_idx),
    .desc_base(desc_base), .desc_count(desc_count),
    .addr_rd_en(addr_rd_en), .addr_rd_idx(addr_rd_idx), .addr_rd_data(addr_rd_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .lamport_rx_valid(lamport_rx_valid), .lamport_rx(lamport_rx), .lamport(lamport),
    .req_done(req_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [TW-1:0]  tb_base [MAX_DEVICES*MAX_PORTS];
  logic [TW:0]    tb_cnt  [MAX_DEVICES*MAX_PORTS];
  address_t       tb_addr [MAX_TARGETS];

  dircc_fanout_pkt_t pkts[$];
  dircc_fanout_pkt_t exp_q[$];
  int                rd_log[$];
  logic [LAMPORT_W-1:0] l_model;
  int errors = 0;
  int checks = 0;

  // Table memories with one-cycle read latency, plus handshake/read monitors.
  always @(posedge clk) begin
    if (desc_rd_en) begin
      desc_base  <= tb_base[desc_rd_idx];
      desc_count <= tb_cnt[desc_rd_idx];
    end
    if (addr_rd_en) begin
      addr_rd_data <= tb_addr[addr_rd_idx];
      rd_log.push_back(int'(addr_rd_idx));
    end
    if (reset_n && pkt_valid && pkt_ready) pkts.push_back(pkt_data);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_exp(input int dev, input int port, input logic [31:0] pl);
    int idx;
    int cnt;
    dircc_fanout_pkt_t p;
    address_t a;
    idx = dev * MAX_PORTS + port;
    cnt = int'(tb_cnt[idx]);
    if (cnt > MAX_TARGETS) cnt = MAX_TARGETS;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      a = tb_addr[(int'(tb_base[idx]) + i) % MAX_TARGETS];
      if (a.flag != DIRCC_ADDRESS_FLAG_DISABLED) begin
        p.dst      = a;
        p.src_dev  = DW'(dev);
        p.src_port = PW'(port);
        p.lamport  = l_model;
        p.payload  = pl;
        exp_q.push_back(p);
      end
    end
  endfunction

  // Called at posedge+2 with the FSM idle; returns at posedge+2 with it idle again.
  task automatic run_req(input int dev, input int port, input logic [31:0] pl,
                         input bit rx_v, input logic [31:0] rx_val,
                         input int stall_pkt, input int stall_len,
                         output int done_lat, output int pv_lat);
    int stall_left;
    dircc_fanout_pkt_t snap;
    pkts.delete();
    rd_log.delete();
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_dev = DW'(dev); req_port = PW'(port); req_payload = pl;
    lamport_rx_valid = rx_v; lamport_rx = rx_val;
    @(posedge clk); #2;
    req_valid = 1'b0; lamport_rx_valid = 1'b0;
    if (rx_v) l_model = ((l_model > rx_val) ? l_model : rx_val) + 32'd2;
    else      l_model = l_model + 32'd1;
    build_exp(dev, port, pl);
    check("lamport_after_accept", lamport, l_model);
    done_lat = -1; pv_lat = -1; stall_left = stall_len;
    for (int k = 1; k <= 400; k++) begin
      if (pkt_valid && pv_lat < 0) pv_lat = k;
      if (pkt_valid && stall_pkt > 0 && pkts.size() == stall_pkt - 1) begin
        if (stall_left == stall_len) snap = pkt_data;
        else check("pkt_data_stable", pkt_data, snap);
        if (stall_left > 0) begin pkt_ready = 1'b0; stall_left--; end
        else pkt_ready = 1'b1;
      end
      if (req_done) begin done_lat = k; break; end
      @(posedge clk); #2;
    end
    pkt_ready = 1'b1;
    if (done_lat < 0) check("req_done_timeout", 0, 1);
    check("pkt_count_model", pkts.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < pkts.size(); j++)
      check($sformatf("pkt%0d", j), pkts[j], exp_q[j]);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    @(posedge clk); #2;
    reset_n = 1'b1;
    l_model = '0;
    @(posedge clk); #2;
  endtask

  task automatic rx_only(input logic [31:0] rx_val);
    lamport_rx_valid = 1'b1; lamport_rx = rx_val;
    @(posedge clk); #2;
    lamport_rx_valid = 1'b0;
    l_model = ((l_model > rx_val) ? l_model : rx_val) + 32'd1;
  endtask

  typedef struct {
    int          dev;
    int          port;
    logic [31:0] payload;
    int          exp_npkts;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   exp_rd[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dl, pl;
    reset_n = 1'b0; req_valid = 1'b0; req_dev = '0; req_port = '0; req_payload = '0;
    pkt_ready = 1'b1; lamport_rx_valid = 1'b0; lamport_rx = '0; l_model = '0;
    for (int i = 0; i < MAX_DEVICES*MAX_PORTS; i++) begin tb_base[i] = '0; tb_cnt[i] = '0; end
    for (int i = 0; i < MAX_TARGETS; i++)
      tb_addr[i] = '{hw_node: 16'(16'h40 + i), sw_node: 8'(i), port: 8'(i % 4), flag: DIRCC_ADDRESS_FLAG_NONE};
    tb_addr[0]  = '{hw_node: 16'd1, sw_node: 8'd0, port: 8'd0, flag: DIRCC_ADDRESS_FLAG_NONE};
    tb_addr[9].flag  = DIRCC_ADDRESS_FLAG_DISABLED;
    tb_addr[12].flag = DIRCC_ADDRESS_FLAG_DISABLED;
    tb_addr[13].flag = DIRCC_ADDRESS_FLAG_DISABLED;
    tb_base[1] = 6'd0;  tb_cnt[1] = 7'd1;
    tb_base[2] = 6'd4;  tb_cnt[2] = 7'd3;
    tb_base[5] = 6'd8;  tb_cnt[5] = 7'd3;
    tb_base[6] = 6'd12; tb_cnt[6] = 7'd2;
    tb_base[7] = 6'd62; tb_cnt[7] = 7'd4;
    tb_base[9] = 6'd0;  tb_cnt[9] = 7'd100;

    vecs[0] = '{dev: 0, port: 1, payload: 32'hA5,   exp_npkts: 1,  exp_lat: 4};
    vecs[1] = '{dev: 0, port: 0, payload: 32'h11,   exp_npkts: 0,  exp_lat: 2};
    vecs[2] = '{dev: 1, port: 1, payload: 32'h22,   exp_npkts: 2,  exp_lat: 7};
    vecs[3] = '{dev: 1, port: 2, payload: 32'h33,   exp_npkts: 0,  exp_lat: 4};
    vecs[4] = '{dev: 1, port: 3, payload: 32'h44,   exp_npkts: 4,  exp_lat: 10};
    vecs[5] = '{dev: 2, port: 1, payload: 32'h55,   exp_npkts: 61, exp_lat: 127};

    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready",  req_ready,  1'b1);
    check("rst_pkt_valid",  pkt_valid,  1'b0);
    check("rst_desc_rd_en", desc_rd_en, 1'b0);
    check("rst_addr_rd_en", addr_rd_en, 1'b0);
    check("rst_req_done",   req_done,   1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_lamport",    lamport,    32'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    for (int v = 0; v < 6; v++) begin
      run_req(vecs[v].dev, vecs[v].port, vecs[v].payload, 1'b0, 32'd0, 0, 0, dl, pl);
      check($sformatf("vec%0d_npkts", v), pkts.size(), vecs[v].exp_npkts);
      check($sformatf("vec%0d_done_lat", v), dl, vecs[v].exp_lat);
      if (vecs[v].exp_npkts > 0) check($sformatf("vec%0d_first_valid_lat", v), pl, 3);
      else check($sformatf("vec%0d_no_valid", v), pl, -1);
    end
    check("lamport_after_vectors", lamport, 32'd6);

    // Backpressure on the second of three packets.
    run_req(0, 2, 32'hBEEF, 1'b0, 32'd0, 2, 5, dl, pl);
    check("stall_npkts", pkts.size(), 3);
    check("stall_order0", pkts.size() > 0 ? pkts[0].dst.hw_node : 16'hFFFF, 16'h44);
    check("stall_order2", pkts.size() > 2 ? pkts[2].dst.hw_node : 16'hFFFF, 16'h46);

    // Address index wraps past the top of the table.
    run_req(1, 3, 32'h77, 1'b0, 32'd0, 0, 0, dl, pl);
    exp_rd[0] = 62; exp_rd[1] = 63; exp_rd[2] = 0; exp_rd[3] = 1;
    check("wrap_reads", rd_log.size(), 4);
    for (int j = 0; j < 4 && j < rd_log.size(); j++)
      check($sformatf("wrap_rd%0d", j), rd_log[j], exp_rd[j]);

    // Lamport merge cases.
    do_reset();
    rx_only(32'd4);
    check("lamport_rx_only", lamport, 32'd5);
    run_req(0, 1, 32'h1, 1'b1, 32'd9, 0, 0, dl, pl);
    check("lamport_rx_and_send", lamport, 32'd11);
    check("stamp_rx_and_send", pkts.size() > 0 ? pkts[0].lamport : 32'hDEAD, 32'd11);
    rx_only(32'd3);
    check("lamport_rx_lower", lamport, 32'd12);
    rx_only(32'hFFFF_FFFE);
    check("lamport_max", lamport, 32'hFFFF_FFFF);
    run_req(0, 1, 32'h2, 1'b0, 32'd0, 0, 0, dl, pl);
    check("lamport_wrap", lamport, 32'd0);
    check("stamp_wrap", pkts.size() > 0 ? pkts[0].lamport : 32'hDEAD, 32'd0);

    // Reset asserted while a packet is being offered.
    pkt_ready = 1'b0;
    req_valid = 1'b1; req_dev = DW'(0); req_port = PW'(2); req_payload = 32'h99;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !pkt_valid; k++) begin @(posedge clk); #2; end
    check("pre_reset_pkt_valid", pkt_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midreset_pkt_valid", pkt_valid, 1'b0);
    check("midreset_busy",      busy,      1'b0);
    check("midreset_req_ready", req_ready, 1'b1);
    check("midreset_lamport",   lamport,   32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    pkt_ready = 1'b1;
    l_model = '0;
    @(posedge clk); #2;
    run_req(0, 1, 32'hA5, 1'b0, 32'd0, 0, 0, dl, pl);
    check("post_reset_npkts", pkts.size(), 1);
    check("post_reset_done_lat", dl, 4);
    check("post_reset_lamport", lamport, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
